// File: rtl/acc_conv_top.sv
// ICB-slave accelerator: 2-channel 3x3 FP16 convolution over NUM_TILES 4x4 tiles, one MAC per cycle.
// Build option: define ACC_WMASK_EN to make data-window writes honour icb_cmd_wmask byte enables.
module acc_conv_top #(
    parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
    parameter int          NUM_TILES = 30,
    parameter int          W_IDX     = 4079
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_addr,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic [31:0] ofmap_out,
    output logic        done,
    output logic        dout_valid
);
    localparam int NPIX = 16 * NUM_TILES;
    localparam int NOUT = 4 * NUM_TILES;
    localparam int AW   = $clog2(NPIX);
    localparam int NW   = $clog2(NOUT);

    // Internal accumulator float: bias-127 exponent, exponent 0 means zero.
    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [15:0] f;
    } ifloat_t;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT, S_DONE} state_t;

    function automatic ifloat_t fp_mul(input logic [15:0] a, input logic [15:0] b);
        ifloat_t     r;
        logic [21:0] p;
        logic [7:0]  es;
        r = '0;
        if (a[14:10] != 5'd0 && b[14:10] != 5'd0) begin
            p   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
            es  = 8'(a[14:10]) + 8'(b[14:10]) + 8'd97;
            r.s = a[15] ^ b[15];
            if (p[21]) begin
                r.e = es + 8'd1;
                r.f = p[20:5];
            end else begin
                r.e = es;
                r.f = p[19:4];
            end
        end
        return r;
    endfunction

    function automatic ifloat_t fp_add(input ifloat_t a, input ifloat_t b);
        ifloat_t     big, sml, r;
        logic [7:0]  d;
        logic [16:0] mb, ms, diff, norm;
        logic [17:0] sum;
        logic [4:0]  lz;
        logic        found;
        r = '0;
        if (a.e == 8'd0) return b;
        if (b.e == 8'd0) return a;
        if ({a.e, a.f} >= {b.e, b.f}) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big.e - sml.e;
        mb = {1'b1, big.f};
        ms = (d > 8'd16) ? 17'd0 : ({1'b1, sml.f} >> d);
        r.s = big.s;
        if (big.s == sml.s) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[17]) begin
                r.e = big.e + 8'd1;
                r.f = sum[16:1];
            end else begin
                r.e = big.e;
                r.f = sum[15:0];
            end
        end else begin
            diff = mb - ms;
            if (diff == 17'd0) begin
                r = '0;
            end else begin
                lz    = 5'd0;
                found = 1'b0;
                for (int k = 16; k >= 0; k--) begin
                    if (!found) begin
                        if (diff[k]) found = 1'b1;
                        else         lz = lz + 5'd1;
                    end
                end
                norm = diff << lz;
                r.e  = big.e - 8'(lz);
                r.f  = norm[15:0];
            end
        end
        return r;
    endfunction

    // Round-to-nearest-even into FP16; results below the normal range flush to 0x0000.
    function automatic logic [15:0] fp_round(input ifloat_t a);
        logic [8:0]  e16;
        logic [11:0] m;
        logic        rnd;
        if (a.e < 8'd113) return 16'h0000;
        e16 = 9'(a.e) - 9'd112;
        rnd = a.f[5] & (a.f[6] | (|a.f[4:0]));
        m   = {2'b01, a.f[15:6]} + 12'(rnd);
        if (m[11]) begin
            e16 = e16 + 9'd1;
            m   = m >> 1;
        end
        if (e16 >= 9'd31) return {a.s, 15'h7BFF};
        return {a.s, e16[4:0], m[9:0]};
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     mem [NPIX];
    logic [31:0]     wt  [9];
    logic [NW-1:0]   n_q;
    logic [1:0]      i_q, j_q;
    logic            ch_q;
    ifloat_t         acc_q, prod, acc_sum;

    logic            accept, busy, start_req, mapped, last_tap, last_out;
    logic            is_ctrl, is_stat, is_data, is_wt, wr_data, wr_wt;
    logic [31:0]     idx, widx32, rd_word;
    logic [AW-1:0]   didx, pix_idx;
    logic [3:0]      widx, tap_idx, byte_en;
    logic [1:0]      row, col;
    logic [31:0]     pix_word, wt_word;
    logic [15:0]     x_h, w_h;

    // ---------------- bus decode ----------------
    assign icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready;
    assign accept        = icb_cmd_valid & icb_cmd_ready;
    assign busy          = (state_q == S_CALC) || (state_q == S_OUT);

    // Both windows rely on unsigned wrap so one compare bounds each side.
    assign idx     = icb_cmd_addr - (BASE_ADDR + 32'd8);
    assign widx32  = idx - 32'(W_IDX);
    assign is_ctrl = (icb_cmd_addr == BASE_ADDR);
    assign is_stat = (icb_cmd_addr == BASE_ADDR + 32'd4);
    assign is_data = (idx < 32'(NPIX));
    assign is_wt   = (widx32 < 32'd9);
    assign mapped  = is_ctrl | is_stat | is_data | is_wt;
    assign didx    = idx[AW-1:0];
    assign widx    = widx32[3:0];

    assign start_req = accept & ~icb_cmd_read & is_ctrl & icb_cmd_wdata[0] & ~busy;
    assign wr_data   = accept & ~icb_cmd_read & is_data & ~busy & ~rst_n;
    assign wr_wt     = accept & ~icb_cmd_read & is_wt   & ~busy & ~rst_n;

`ifdef ACC_WMASK_EN
    assign byte_en = icb_cmd_wmask;
`else
    logic unused_wmask;
    assign unused_wmask = ^icb_cmd_wmask;
    assign byte_en      = 4'hF;
`endif

    always_comb begin
        rd_word = '0;
        if (is_stat)      rd_word = {30'd0, busy, done};
        else if (is_data) rd_word = mem[didx];
        else if (is_wt)   rd_word = wt[widx];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            icb_rsp_valid <= 1'b0;
            icb_rsp_rdata <= '0;
            icb_rsp_err   <= 1'b0;
        end else if (accept) begin
            icb_rsp_valid <= 1'b1;
            icb_rsp_rdata <= (icb_cmd_read && mapped) ? rd_word : 32'd0;
            icb_rsp_err   <= ~mapped;
        end else if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
        end
    end

    // Storage is intentionally left uninitialised across reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_data && byte_en[b]) mem[didx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
            if (wr_wt && byte_en[b])   wt[widx][8*b +: 8]  <= icb_cmd_wdata[8*b +: 8];
        end
    end

    // ---------------- MAC datapath ----------------
    assign row      = {1'b0, n_q[1]} + i_q;
    assign col      = {1'b0, n_q[0]} + j_q;
    assign pix_idx  = {n_q[NW-1:2], row, col};
    assign tap_idx  = {2'b00, i_q} * 4'd3 + {2'b00, j_q};
    assign pix_word = mem[pix_idx];
    assign wt_word  = wt[tap_idx];
    assign x_h      = ch_q ? pix_word[31:16] : pix_word[15:0];
    assign w_h      = ch_q ? wt_word[31:16]  : wt_word[15:0];
    assign prod     = fp_mul(x_h, w_h);
    assign acc_sum  = fp_add(acc_q, prod);

    assign last_tap = ch_q && (i_q == 2'd2) && (j_q == 2'd2);
    assign last_out = (n_q == NW'(NOUT - 1));

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start_req) state_d = S_CALC;
            S_CALC:         if (last_tap)  state_d = S_OUT;
            S_OUT:          state_d = last_out ? S_DONE : S_CALC;
            default:        state_d = S_IDLE;
        endcase
    end

    assign dout_valid = (state_q == S_OUT);
    assign done       = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            ofmap_out <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            ch_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        acc_q <= '0;
                        n_q   <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                        ch_q  <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_sum;
                    if (j_q == 2'd2) begin
                        j_q <= '0;
                        if (i_q == 2'd2) begin
                            i_q  <= '0;
                            ch_q <= ~ch_q;
                        end else begin
                            i_q <= i_q + 2'd1;
                        end
                    end else begin
                        j_q <= j_q + 2'd1;
                    end
                    if (last_tap) ofmap_out <= {16'd0, fp_round(acc_sum)};
                end
                S_OUT: begin
                    acc_q <= '0;
                    n_q   <= n_q + NW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_conv_top.sv
// Scoreboard bench for acc_conv_top: expected results are queued at start, checked on each dout_valid.
module tb_acc_conv_top;
    localparam logic [31:0] BASE = 32'h1004_2000;
    localparam int NPIX = 480;
    localparam int NOUT = 120;
    localparam int WI   = 4079;

    logic        clk, rst_n;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata, ofmap_out;
    logic        done, dout_valid;

    acc_conv_top dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .ofmap_out(ofmap_out), .done(done), .dout_valid(dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        real         val;
        bit          tol;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pix [NPIX];
    logic [31:0] wts [9];

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(int'(h[9:0])) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] rand_h(input int elo, input int ehi);
        logic [4:0] e;
        logic [9:0] m;
        logic       s;
        e = 5'($urandom_range(ehi, elo));
        m = 10'($urandom);
        s = 1'($urandom_range(1, 0));
        return {s, e, m};
    endfunction

    // Output monitor / scoreboard comparator
    always @(negedge clk) begin
        exp_t e;
        real  got, err, lim;
        if (dout_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: ofmap_out=%h while nothing expected", ofmap_out);
            end else begin
                e = sb.pop_front();
                if (e.tol) begin
                    got = h2r(ofmap_out[15:0]);
                    err = got - e.val;
                    if (err < 0.0) err = -err;
                    lim = (e.val < 0.0) ? -e.val : e.val;
                    lim = 0.004 + lim / 1024.0;
                    if (ofmap_out[31:16] !== 16'h0 || err > lim) begin
                        n_fail++;
                        $display("FAIL result_tol: got %h (%f) want %f +/- %f", ofmap_out, got, e.val, lim);
                    end
                end else if (ofmap_out !== {16'h0, e.bits}) begin
                    n_fail++;
                    $display("FAIL result_exact: got %h want %h", ofmap_out, {16'h0, e.bits});
                end
            end
        end
    end

    task automatic bus_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdata, output logic err);
        int cnt;
        @(negedge clk);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = 4'hF;
        cnt = 0;
        while (!icb_cmd_ready && cnt < 50) begin @(negedge clk); cnt++; end
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        while (!icb_rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
        if (cnt >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout: addr=%h no handshake within 50 cycles", addr);
        end
        rdata = icb_rsp_rdata;
        err   = icb_rsp_err;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        bus_xfer(1'b0, addr, data, d, e);
    endtask

    task automatic load_pixels();
        for (int k = 0; k < NPIX; k++) wr(BASE + 32'd8 + 32'(k), pix[k]);
    endtask

    task automatic load_weights();
        for (int m = 0; m < 9; m++) wr(BASE + 32'd8 + 32'(WI + m), wts[m]);
    endtask

    // mode 0: constant result, 1: centre pixel of ch1, 2: real-valued model with tolerance
    task automatic push_run(input int mode, input logic [15:0] cbits);
        exp_t e;
        int   t, r, c;
        for (int n = 0; n < NOUT; n++) begin
            t = n / 4; r = (n % 4) / 2; c = n % 2;
            e.bits = cbits; e.val = 0.0; e.tol = 1'b0;
            if (mode == 1) e.bits = pix[t*16 + (r+1)*4 + c + 1][15:0];
            if (mode == 2) begin
                e.tol = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        e.val += h2r(pix[t*16 + (r+i)*4 + c + j][15:0])  * h2r(wts[i*3+j][15:0]);
                        e.val += h2r(pix[t*16 + (r+i)*4 + c + j][31:16]) * h2r(wts[i*3+j][31:16]);
                    end
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int cnt;
        cnt = 0;
        while (!done && cnt < 5000) begin @(negedge clk); cnt++; end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, want 1", name, done, cnt);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_count: %0d results missing, want 0", name, sb.size());
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_hold: done=%b dout_valid=%b want 1/0", name, done, dout_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dout_valid, done, icb_rsp_valid, icb_rsp_err} !== 4'b0 || ofmap_out !== 32'h0 ||
            icb_rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: dv=%b done=%b rv=%b err=%b of=%h rd=%h want all 0",
                     dout_valid, done, icb_rsp_valid, icb_rsp_err, ofmap_out, icb_rsp_rdata);
        end
        n_checks++;
        if (icb_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b want 1", icb_cmd_ready);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_bus_map();
        logic [31:0] d;
        logic        e;
        wr(BASE + 32'd8 + 32'd3, 32'hABCD_1234);
        bus_xfer(1'b1, BASE + 32'd8 + 32'd3, 32'h0, d, e);
        n_checks++;
        if (d !== 32'hABCD_1234 || e !== 1'b0) begin
            n_fail++; $display("FAIL data_readback: got %h err=%b want abcd1234 err=0", d, e);
        end
        wr(BASE + 32'd8 + 32'(WI + 8), 32'h5A5A_A5A5);
        bus_xfer(1'b1, BASE + 32'd8 + 32'(WI + 8), 32'h0, d, e);
        n_checks++;
        if (d !== 32'h5A5A_A5A5 || e !== 1'b0) begin
            n_fail++; $display("FAIL weight_readback: got %h err=%b want 5a5aa5a5 err=0", d, e);
        end
        bus_xfer(1'b1, BASE + 32'h1000_0000, 32'h0, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_read: got %h err=%b want 0 err=1", d, e);
        end
        bus_xfer(1'b1, BASE + 32'd8 + 32'(NPIX), 32'h0, d, e);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL data_end_err: got err=%b want 1", e); end
        bus_xfer(1'b1, BASE + 32'd8 + 32'(WI - 1), 32'h0, d, e);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL wt_below_err: got err=%b want 1", e); end
        bus_xfer(1'b1, BASE + 32'd8 + 32'(WI + 9), 32'h0, d, e);
        n_checks++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL wt_above_err: got err=%b want 1", e); end
        bus_xfer(1'b1, BASE, 32'h0, d, e);
        n_checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            n_fail++; $display("FAIL ctrl_read: got %h err=%b want 0 err=0", d, e);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = BASE + 32'd8 + 32'd3;
        @(negedge clk);
        icb_cmd_addr = BASE + 32'd8 + 32'(WI + 8);
        repeat (3) begin
            n_checks++;
            if (icb_cmd_ready !== 1'b0 || icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hABCD_1234) begin
                n_fail++;
                $display("FAIL backpressure_hold: ready=%b rv=%b rdata=%h want 0/1/abcd1234",
                         icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata);
            end
            @(negedge clk);
        end
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        n_checks++;
        if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h5A5A_A5A5) begin
            n_fail++;
            $display("FAIL backpressure_next: rv=%b rdata=%h want 1/5a5aa5a5", icb_rsp_valid, icb_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_ones();
        logic [31:0] d;
        logic        e;
        for (int k = 0; k < NPIX; k++) pix[k] = 32'h3C00_3C00;
        for (int m = 0; m < 9; m++) wts[m] = 32'h3C00_3C00;
        load_pixels();
        load_weights();
        push_run(0, 16'h4C80);
        wr(BASE, 32'h1);
        repeat (50) @(negedge clk);
        bus_xfer(1'b1, BASE + 32'd4, 32'h0, d, e);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL status_busy: got %h want 00000002", d); end
        wait_done("ones");
        bus_xfer(1'b1, BASE + 32'd4, 32'h0, d, e);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL status_done: got %h want 00000001", d); end
    endtask

    task automatic test_cancel();
        for (int m = 0; m < 9; m++) wts[m] = 32'hBC00_3C00;
        load_weights();
        push_run(0, 16'h0000);
        wr(BASE, 32'h1);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL restart_clears_done: got %b want 0", done); end
        wait_done("cancel");
    endtask

    task automatic test_center();
        logic [31:0] d;
        logic        e;
        for (int k = 0; k < NPIX; k++) pix[k] = {rand_h(1, 30), rand_h(1, 30)};
        for (int m = 0; m < 9; m++) wts[m] = 32'h0;
        wts[4] = 32'h0000_3C00;
        load_pixels();
        load_weights();
        push_run(1, 16'h0);
        wr(BASE, 32'h1);
        bus_xfer(1'b0, BASE + 32'd8 + 32'd3, 32'hDEAD_BEEF, d, e);
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL busy_write_err: got %b want 0", e); end
        wait_done("center");
        bus_xfer(1'b1, BASE + 32'd8 + 32'd3, 32'h0, d, e);
        n_checks++;
        if (d !== pix[3]) begin n_fail++; $display("FAIL busy_write_dropped: got %h want %h", d, pix[3]); end
    endtask

    task automatic test_busy_ctrl();
        for (int k = 0; k < NPIX; k++) pix[k] = {rand_h(13, 14), rand_h(13, 14)};
        for (int m = 0; m < 9; m++) wts[m] = {rand_h(13, 14), rand_h(13, 14)};
        load_pixels();
        load_weights();
        push_run(2, 16'h0);
        wr(BASE, 32'h1);
        @(negedge clk);
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = BASE; icb_cmd_wdata = 32'h0;
        repeat (600) @(negedge clk);
        icb_cmd_valid = 1'b0;
        n_checks++;
        if (icb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL ctrl_zero_err: got %b want 0", icb_rsp_err); end
        wr(BASE, 32'h1);
        wait_done("busy_ctrl");
    endtask

    task automatic test_reset_midrun();
        push_run(2, 16'h0);
        wr(BASE, 32'h1);
        repeat (400) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        n_checks++;
        if (done !== 1'b0 || dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset: done=%b dv=%b want 0/0", done, dout_valid);
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: done=%b want 0", done); end
        push_run(2, 16'h0);
        wr(BASE, 32'h1);
        wait_done("rerun");
    endtask

    initial begin
        rst_n         = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'hF;
        icb_rsp_ready = 1'b1;
        test_reset();
        test_bus_map();
        test_backpressure();
        test_ones();
        test_cancel();
        test_center();
        test_busy_ctrl();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
